// File: rtl/riscv_core_pkg.sv
// Shared definitions for the machine-mode trap path: CSR addresses, cause codes,
// mstatus bit positions and the trap sequencer state encoding.
package riscv_core_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  // Order of this table defines the select-vector index of each owned CSR.
  localparam int CSR_COUNT    = 6;
  localparam int SEL_MSTATUS  = 0;
  localparam int SEL_MTVEC    = 1;
  localparam int SEL_MSCRATCH = 2;
  localparam int SEL_MEPC     = 3;
  localparam int SEL_MCAUSE   = 4;
  localparam int SEL_MTVAL    = 5;
  localparam logic [11:0] CSR_ADDR_TABLE [CSR_COUNT] = '{
    CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL
  };

  localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;
  localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} trap_state_e;
  typedef enum logic [1:0] {TRAP_NONE, TRAP_ECALL, TRAP_EBREAK, TRAP_MRET} trap_kind_e;

  // Strobes should be one-hot; if not, ecall beats ebreak beats mret.
  function automatic trap_kind_e decode_trap(input logic ecall, input logic ebreak,
                                             input logic mret);
    if (ecall)       return TRAP_ECALL;
    else if (ebreak) return TRAP_EBREAK;
    else if (mret)   return TRAP_MRET;
    else             return TRAP_NONE;
  endfunction

endpackage

// File: rtl/riscv_core_trap_csr_regs.sv
// Storage, write masking and read mux for mstatus/mtvec/mscratch/mepc/mcause/mtval.
// Trap entry/return updates take precedence over software writes to the same CSR.
module riscv_core_trap_csr_regs
  import riscv_core_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] P_MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  input  logic            trap_enter,
  input  logic            trap_is_ebreak,
  input  logic            trap_return,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic [CSR_COUNT-1:0] addr_sel;
  logic [CSR_COUNT-1:0] wr_sel;

  logic            mie_reg, mie_next;
  logic            mpie_reg, mpie_next;
  logic [XLEN-1:0] mtvec_reg, mtvec_next;
  logic [XLEN-1:0] mscratch_reg, mscratch_next;
  logic [XLEN-1:0] mepc_reg, mepc_next;
  logic [XLEN-1:0] mcause_reg, mcause_next;
  logic [XLEN-1:0] mtval_reg, mtval_next;
  logic [XLEN-1:0] mstatus_view;

  genvar gi;
  generate
    for (gi = 0; gi < CSR_COUNT; gi++) begin : g_sel
      assign addr_sel[gi] = (csr_addr == CSR_ADDR_TABLE[gi]);
      assign wr_sel[gi]   = csr_we & addr_sel[gi];
    end
  endgenerate

  assign csr_hit = |addr_sel;

  always_comb begin
    mie_next      = mie_reg;
    mpie_next     = mpie_reg;
    mtvec_next    = mtvec_reg;
    mscratch_next = mscratch_reg;
    mepc_next     = mepc_reg;
    mcause_next   = mcause_reg;
    mtval_next    = mtval_reg;

    if (wr_sel[SEL_MSTATUS]) begin
      mie_next  = csr_wdata[MSTATUS_MIE_BIT];
      mpie_next = csr_wdata[MSTATUS_MPIE_BIT];
    end
    if (wr_sel[SEL_MTVEC])    mtvec_next    = {csr_wdata[XLEN-1:2], 2'b00};
    if (wr_sel[SEL_MSCRATCH]) mscratch_next = csr_wdata;
    if (wr_sel[SEL_MEPC])     mepc_next     = {csr_wdata[XLEN-1:1], 1'b0};
    if (wr_sel[SEL_MCAUSE])   mcause_next   = csr_wdata;
    if (wr_sel[SEL_MTVAL])    mtval_next    = csr_wdata;

    if (trap_enter) begin
      mpie_next   = mie_reg;
      mie_next    = 1'b0;
      mepc_next   = {trap_pc[XLEN-1:1], 1'b0};
      mcause_next = trap_is_ebreak ? XLEN'(CAUSE_BREAKPOINT) : XLEN'(CAUSE_ECALL_M);
      mtval_next  = trap_is_ebreak ? trap_pc : '0;
    end else if (trap_return) begin
      mie_next  = mpie_reg;
      mpie_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mtvec_reg    <= P_MTVEC_RESET;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mtval_reg    <= '0;
    end else begin
      mie_reg      <= mie_next;
      mpie_reg     <= mpie_next;
      mtvec_reg    <= mtvec_next;
      mscratch_reg <= mscratch_next;
      mepc_reg     <= mepc_next;
      mcause_reg   <= mcause_next;
      mtval_reg    <= mtval_next;
    end
  end

  // Only M-mode exists, so MPP is hardwired to 2'b11.
  always_comb begin
    mstatus_view                                 = '0;
    mstatus_view[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    mstatus_view[MSTATUS_MIE_BIT]                = mie_reg;
    mstatus_view[MSTATUS_MPIE_BIT]               = mpie_reg;
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_view;
      CSR_MTVEC:    csr_rdata = mtvec_reg;
      CSR_MSCRATCH: csr_rdata = mscratch_reg;
      CSR_MEPC:     csr_rdata = mepc_reg;
      CSR_MCAUSE:   csr_rdata = mcause_reg;
      CSR_MTVAL:    csr_rdata = mtval_reg;
      default:      csr_rdata = '0;
    endcase
  end

  assign mtvec = mtvec_reg;
  assign mepc  = mepc_reg;

endmodule

// File: rtl/riscv_core_trap_handler.sv
// Machine-mode trap sequencer: takes ecall/ebreak/mret at writeback, updates the trap
// CSRs, pulses a flush and holds a PC redirect until fetch accepts it.
module riscv_core_trap_handler
  import riscv_core_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] P_MTVEC_RESET = '0
) (
  input  logic            i_trap_clk,
  input  logic            i_trap_rst_n,
  input  logic            i_trap_valid,
  input  logic            i_trap_ecall,
  input  logic            i_trap_ebreak,
  input  logic            i_trap_mret,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_trap_csr_we,
  input  logic [11:0]     i_trap_csr_addr,
  input  logic [XLEN-1:0] i_trap_csr_wdata,
  output logic [XLEN-1:0] o_trap_csr_rdata,
  output logic            o_trap_csr_hit,
  output logic            o_trap_redirect_valid,
  input  logic            i_trap_redirect_ready,
  output logic [XLEN-1:0] o_trap_redirect_target,
  output logic            o_trap_flush,
  output logic            o_trap_stall
);

  trap_state_e     state_reg, state_next;
  trap_kind_e      kind;
  logic            trap_event;
  logic            trap_enter;
  logic            trap_return;
  logic            flush_reg;
  logic [XLEN-1:0] target_reg, target_next;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  assign kind        = i_trap_valid ? decode_trap(i_trap_ecall, i_trap_ebreak, i_trap_mret)
                                    : TRAP_NONE;
  // Retirements seen while a redirect is outstanding are deliberately dropped.
  assign trap_event  = (state_reg == IDLE) && (kind != TRAP_NONE);
  assign trap_enter  = trap_event && ((kind == TRAP_ECALL) || (kind == TRAP_EBREAK));
  assign trap_return = trap_event && (kind == TRAP_MRET);

  riscv_core_trap_csr_regs #(
    .XLEN          (XLEN),
    .P_MTVEC_RESET (P_MTVEC_RESET)
  ) u_csr_regs (
    .clk            (i_trap_clk),
    .rst_n          (i_trap_rst_n),
    .csr_we         (i_trap_csr_we),
    .csr_addr       (i_trap_csr_addr),
    .csr_wdata      (i_trap_csr_wdata),
    .csr_rdata      (o_trap_csr_rdata),
    .csr_hit        (o_trap_csr_hit),
    .trap_enter     (trap_enter),
    .trap_is_ebreak (kind == TRAP_EBREAK),
    .trap_return    (trap_return),
    .trap_pc        (i_trap_pc),
    .mtvec          (mtvec),
    .mepc           (mepc)
  );

  always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
    if (!i_trap_rst_n) state_reg <= IDLE;
    else               state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trap_event) state_next = REDIR;
      REDIR:   if (i_trap_redirect_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_trap_redirect_valid = 1'b0;
    o_trap_stall          = 1'b0;
    if (state_reg == REDIR) begin
      o_trap_redirect_valid = 1'b1;
      o_trap_stall          = 1'b1;
    end
  end

  // Target is built from the pre-update CSR values so a same-cycle write cannot leak in.
  always_comb begin
    target_next = target_reg;
    if (trap_enter)       target_next = mtvec & ~XLEN'(3);
    else if (trap_return) target_next = mepc & ~XLEN'(1);
  end

  always_ff @(posedge i_trap_clk or negedge i_trap_rst_n) begin
    if (!i_trap_rst_n) begin
      target_reg <= '0;
      flush_reg  <= 1'b0;
    end else begin
      target_reg <= target_next;
      flush_reg  <= trap_event;
    end
  end

  assign o_trap_redirect_target = target_reg;
  assign o_trap_flush           = flush_reg;

endmodule

// File: tb/tb_riscv_core_trap_handler.sv
// Self-checking bench for the trap sequencer: directed scenarios plus a randomized run
// compared against a behavioural model of the CSR/trap rules.
module tb_riscv_core_trap_handler;

  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, ecall = 1'b0, ebreak = 1'b0, mret = 1'b0;
  logic [63:0] pc = '0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [63:0] rdata;
  logic        hit;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [63:0] target;
  logic        flush;
  logic        stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_core_trap_handler #(
    .XLEN          (64),
    .P_MTVEC_RESET (MTVEC_RST)
  ) dut (
    .i_trap_clk             (clk),
    .i_trap_rst_n           (rst_n),
    .i_trap_valid           (valid),
    .i_trap_ecall           (ecall),
    .i_trap_ebreak          (ebreak),
    .i_trap_mret            (mret),
    .i_trap_pc              (pc),
    .i_trap_csr_we          (csr_we),
    .i_trap_csr_addr        (csr_addr),
    .i_trap_csr_wdata       (csr_wdata),
    .o_trap_csr_rdata       (rdata),
    .o_trap_csr_hit         (hit),
    .o_trap_redirect_valid  (rvalid),
    .i_trap_redirect_ready  (rready),
    .o_trap_redirect_target (target),
    .o_trap_flush           (flush),
    .o_trap_stall           (stall)
  );

  // Behavioural model: architectural CSR values plus "redirect outstanding" flag.
  logic        m_mie, m_mpie, m_busy, m_flush;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_target;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_busy = 0; m_flush = 0;
    m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_target = 0;
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic model_hit(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
  endfunction

  // Advance one clock: compute what the model expects from the current inputs, then commit.
  task automatic tick();
    logic        ev;
    logic        n_mie, n_mpie, n_busy;
    logic [63:0] n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_target;
    ev = !m_busy && valid && (ecall || ebreak || mret);
    n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
    n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval; n_target = m_target;
    if (csr_we) begin
      case (csr_addr)
        12'h300: begin n_mie = csr_wdata[3]; n_mpie = csr_wdata[7]; end
        12'h305: n_mtvec = csr_wdata & ~64'h3;
        12'h340: n_mscratch = csr_wdata;
        12'h341: n_mepc = csr_wdata & ~64'h1;
        12'h342: n_mcause = csr_wdata;
        12'h343: n_mtval = csr_wdata;
        default: ;
      endcase
    end
    if (ev) begin
      if (ecall || ebreak) begin
        n_mepc   = pc & ~64'h1;
        n_mcause = ecall ? 64'd11 : 64'd3;
        n_mtval  = ecall ? 64'd0 : pc;
        n_mpie   = m_mie;
        n_mie    = 1'b0;
        n_target = m_mtvec & ~64'h3;
      end else begin
        n_mie    = m_mpie;
        n_mpie   = 1'b1;
        n_target = m_mepc & ~64'h1;
      end
    end
    n_busy = m_busy ? !rready : ev;
    @(posedge clk); #1;
    m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
    m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_target = n_target;
    m_busy = n_busy; m_flush = ev;
  endtask

  task automatic clear_inputs();
    valid = 0; ecall = 0; ebreak = 0; mret = 0; csr_we = 0; rready = 0;
  endtask

  task automatic test_reset();
    logic [11:0] a[3] = '{12'h300, 12'h305, 12'h7C0};
    logic [63:0] e[3] = '{64'h1800, MTVEC_RST, 64'h0};
    logic        h[3] = '{1'b1, 1'b1, 1'b0};
    clear_inputs();
    rst_n = 0;
    #12;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rvalid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
    total++; if (target !== 64'h0) begin bad++; $display("FAIL reset_target got=%h want=0", target); end
    @(negedge clk); rst_n = 1; model_reset();
    foreach (a[i]) begin
      csr_addr = a[i]; #1;
      total++;
      if (rdata !== e[i] || hit !== h[i]) begin
        bad++; $display("FAIL reset_csr addr=%h got=%h/%b want=%h/%b", a[i], rdata, hit, e[i], h[i]);
      end
    end
    $display("reset: csr reset values read back");
  endtask

  task automatic test_ecall();
    logic [11:0] a[5] = '{12'h341, 12'h342, 12'h343, 12'h300, 12'h305};
    logic [63:0] e[5] = '{64'h8000_0040, 64'd11, 64'd0, 64'h1880, 64'h8000_0100};
    clear_inputs();
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 64'h8000_0103; tick();
    csr_addr = 12'h300; csr_wdata = 64'h8; tick();
    csr_we = 0; valid = 1; ecall = 1; pc = 64'h8000_0040; tick();
    clear_inputs();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL ecall_flush got=%b want=1", flush); end
    total++; if (rvalid !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL ecall_valid got=%b/%b want=1/1", rvalid, stall); end
    total++; if (target !== 64'h8000_0100) begin bad++; $display("FAIL ecall_target got=%h want=%h", target, 64'h8000_0100); end
    foreach (a[i]) begin
      csr_addr = a[i]; #1;
      total++; if (rdata !== e[i]) begin bad++; $display("FAIL ecall_csr addr=%h got=%h want=%h", a[i], rdata, e[i]); end
    end
    rready = 1; tick(); rready = 0;
    total++; if (rvalid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL ecall_release got=%b/%b want=0/0", rvalid, flush); end
    $display("ecall: pc=%h target=%h", 64'h8000_0040, target);
  endtask

  task automatic test_ebreak();
    logic [11:0] a[3] = '{12'h342, 12'h343, 12'h341};
    logic [63:0] e[3] = '{64'd3, 64'h8000_0082, 64'h8000_0082};
    clear_inputs();
    valid = 1; ebreak = 1; pc = 64'h8000_0082; tick();
    clear_inputs();
    total++; if (rvalid !== 1'b1 || target !== 64'h8000_0100) begin bad++; $display("FAIL ebreak_redirect got=%b/%h want=1/%h", rvalid, target, 64'h8000_0100); end
    foreach (a[i]) begin
      csr_addr = a[i]; #1;
      total++; if (rdata !== e[i]) begin bad++; $display("FAIL ebreak_csr addr=%h got=%h want=%h", a[i], rdata, e[i]); end
    end
    rready = 1; tick(); rready = 0;
    $display("ebreak: pc=%h", 64'h8000_0082);
  endtask

  task automatic test_mret();
    clear_inputs();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 64'h8000_0045; tick();
    csr_addr = 12'h300; csr_wdata = 64'h80; tick();
    csr_we = 0; valid = 1; mret = 1; tick();
    clear_inputs();
    total++; if (flush !== 1'b1 || target !== 64'h8000_0044) begin bad++; $display("FAIL mret_target got=%b/%h want=1/%h", flush, target, 64'h8000_0044); end
    csr_addr = 12'h300; #1;
    total++; if (rdata !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h want=%h", rdata, 64'h1888); end
    csr_addr = 12'h341; #1;
    total++; if (rdata !== 64'h8000_0044) begin bad++; $display("FAIL mret_mepc got=%h want=%h", rdata, 64'h8000_0044); end
    rready = 1; tick(); rready = 0;
    $display("mret: target=%h", 64'h8000_0044);
  endtask

  task automatic test_hold();
    clear_inputs();
    valid = 1; ecall = 1; pc = 64'h200; tick();
    for (int c = 0; c < 3; c++) begin
      clear_inputs(); valid = 1; ebreak = 1; pc = 64'h300; tick();
      total++;
      if (rvalid !== 1'b1 || stall !== 1'b1 || flush !== 1'b0 || target !== 64'h8000_0100) begin
        bad++; $display("FAIL hold_cycle%0d got=%b/%b/%b/%h want=1/1/0/%h", c, rvalid, stall, flush, target, 64'h8000_0100);
      end
    end
    clear_inputs();
    csr_addr = 12'h342; #1;
    total++; if (rdata !== 64'd11) begin bad++; $display("FAIL hold_mcause got=%h want=%h", rdata, 64'd11); end
    csr_addr = 12'h341; #1;
    total++; if (rdata !== 64'h200) begin bad++; $display("FAIL hold_mepc got=%h want=%h", rdata, 64'h200); end
    rready = 1; tick(); rready = 0;
    total++; if (rvalid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL hold_release got=%b/%b want=0/0", rvalid, stall); end
    $display("hold: redirect held 3 cycles, then accepted");
  endtask

  task automatic test_collide();
    clear_inputs();
    csr_we = 1; csr_addr = 12'h341; csr_wdata = 64'h1234; valid = 1; ecall = 1; pc = 64'h100; tick();
    clear_inputs();
    csr_addr = 12'h341; #1;
    total++; if (rdata !== 64'h100) begin bad++; $display("FAIL collide_mepc got=%h want=%h", rdata, 64'h100); end
    rready = 1; tick(); rready = 0;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 64'h4000; valid = 1; ebreak = 1; pc = 64'h104; tick();
    clear_inputs();
    total++; if (target !== 64'h8000_0100) begin bad++; $display("FAIL collide_target got=%h want=%h", target, 64'h8000_0100); end
    csr_addr = 12'h305; #1;
    total++; if (rdata !== 64'h4000) begin bad++; $display("FAIL collide_mtvec got=%h want=%h", rdata, 64'h4000); end
    rst_n = 0; #1;
    total++; if (rvalid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL redir_reset got=%b/%b want=0/0", rvalid, stall); end
    @(negedge clk); rst_n = 1; model_reset();
    $display("collide: trap beat csr write, async reset cleared redirect");
  endtask

  task automatic test_random();
    logic [11:0] tbl[6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
    int start_bad;
    start_bad = bad;
    for (int n = 0; n < 400; n++) begin
      int pick;
      pick = $urandom_range(0, 7);
      valid = ($urandom_range(0, 2) == 0);
      {ecall, ebreak, mret} = 3'($urandom);
      pc = {$urandom, $urandom};
      csr_we = ($urandom_range(0, 3) == 0);
      csr_wdata = {$urandom, $urandom};
      csr_addr = (pick < 6) ? tbl[pick] : ((pick == 6) ? 12'h344 : 12'($urandom));
      rready = $urandom_range(0, 1);
      #1;
      total++; if (rdata !== model_read(csr_addr)) begin bad++; $display("FAIL rand_rdata n=%0d addr=%h got=%h want=%h", n, csr_addr, rdata, model_read(csr_addr)); end
      total++; if (hit !== model_hit(csr_addr)) begin bad++; $display("FAIL rand_hit n=%0d addr=%h got=%b want=%b", n, csr_addr, hit, model_hit(csr_addr)); end
      total++; if (rvalid !== m_busy || stall !== m_busy) begin bad++; $display("FAIL rand_valid n=%0d got=%b/%b want=%b", n, rvalid, stall, m_busy); end
      total++; if (flush !== m_flush) begin bad++; $display("FAIL rand_flush n=%0d got=%b want=%b", n, flush, m_flush); end
      total++; if (target !== m_target) begin bad++; $display("FAIL rand_target n=%0d got=%h want=%h", n, target, m_target); end
      tick();
    end
    clear_inputs();
    $display("random: 400 cycles, %0d new failures", bad - start_bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ecall();
    test_ebreak();
    test_mret();
    test_hold();
    test_collide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
